// File: rtl/mem_loader_pkg.sv
// Shared types and helpers for the memory stream loader.
//   state_e        : loader FSM states
//   bytes_per_word : number of stream bytes that make one memory word
package mem_loader_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StVerify = 2'd2,
    StDone   = 2'd3
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/mem_stream_loader_if.sv
// Byte-stream input and Memory expansion-port bundle for the loader.
//   in_data/in_valid/in_ready : byte stream (valid/ready)
//   exp_address/exp_data      : expansion-port address and write data
//   exp_MW/exp_MR             : write strobe / read enable
//   exp_out                   : combinational read data from Memory
// master = loader side, slave = stream source + Memory side.
interface mem_stream_loader_if #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned WIDTH     = 16
);
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_SIZE-1:0] exp_address;
  logic [WIDTH-1:0]     exp_data;
  logic                 exp_MW;
  logic                 exp_MR;
  logic [WIDTH-1:0]     exp_out;

  modport master (
    input  in_data, in_valid, exp_out,
    output in_ready, exp_address, exp_data, exp_MW, exp_MR
  );

  modport slave (
    output in_data, in_valid, exp_out,
    input  in_ready, exp_address, exp_data, exp_MW, exp_MR
  );
endinterface

// File: rtl/mem_word_packer.sv
// Packs accepted stream bytes into big-endian words.
//   clk, rst   : clock, synchronous active-high reset (discards a partial word)
//   take       : a byte is accepted this cycle
//   in_data    : the byte being accepted
//   word       : packed word, valid while word_valid is high
//   word_valid : one-cycle pulse the cycle after the last byte of a word is taken
module mem_word_packer
  import mem_loader_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             take,
  input  logic [7:0]       in_data,
  output logic [WIDTH-1:0] word,
  output logic             word_valid
);

  localparam int unsigned Bpw  = bytes_per_word(WIDTH);
  localparam int unsigned CntW = (Bpw > 1) ? $clog2(Bpw) : 1;

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (take) begin
        // First byte ends up in the MSBs once the word is complete.
        sh_q <= WIDTH'({sh_q, in_data});
        if (cnt_q == CntW'(Bpw - 1)) begin
          cnt_q   <= '0;
          valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign word       = sh_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/mem_stream_loader.sv
// Loads a byte stream into Memory through its expansion port, then reads the
// image back and compares the readback checksum with the load checksum.
//   clk, rst : clock, synchronous active-high reset
//   start    : begin a load (honoured only when idle or done)
//   count    : words to load, latched on start; values above 2**ADDR_SIZE clamp
//   bus      : byte stream + expansion port (master side)
//   busy     : loader owns the expansion port (LOAD/VERIFY)
//   done     : load and verify finished
//   ok       : checksums matched; meaningful only while done is high
module mem_stream_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_SIZE:0]   count,
  mem_stream_loader_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 ok
);

  localparam logic [ADDR_SIZE:0] MaxCount = {1'b1, {ADDR_SIZE{1'b0}}};

  state_e             state_q;
  logic [ADDR_SIZE:0] idx_q;
  logic [ADDR_SIZE:0] count_q;
  logic [WIDTH-1:0]   load_sum_q;
  logic [WIDTH-1:0]   read_sum_q;
  logic               ok_q;

  logic               take;
  logic [WIDTH-1:0]   pack_word;
  logic               pack_valid;
  logic [ADDR_SIZE:0] count_clamped;
  logic               last_idx;

  // Anything with the top bit set and a non-zero remainder exceeds the memory size.
  assign count_clamped = (count[ADDR_SIZE] && (|count[ADDR_SIZE-1:0])) ? MaxCount : count;
  assign last_idx      = (idx_q == count_q - 1'b1);

  // in_ready drops on the write cycle, giving the one-cycle bubble per word.
  assign bus.in_ready = (state_q == StLoad) && !pack_valid;
  assign take         = bus.in_valid && bus.in_ready;

  mem_word_packer #(
    .WIDTH (WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .take       (take),
    .in_data    (bus.in_data),
    .word       (pack_word),
    .word_valid (pack_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      count_q    <= '0;
      load_sum_q <= '0;
      read_sum_q <= '0;
      ok_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            idx_q      <= '0;
            count_q    <= count_clamped;
            load_sum_q <= '0;
            read_sum_q <= '0;
            if (count_clamped == '0) begin
              ok_q    <= 1'b1;
              state_q <= StDone;
            end else begin
              ok_q    <= 1'b0;
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (pack_valid) begin
            load_sum_q <= load_sum_q + pack_word;
            if (last_idx) begin
              idx_q   <= '0;
              state_q <= StVerify;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StVerify: begin
          read_sum_q <= read_sum_q + bus.exp_out;
          if (last_idx) begin
            idx_q   <= '0;
            // Fold in the final read word so ok is ready on entry to DONE.
            ok_q    <= ((read_sum_q + bus.exp_out) == load_sum_q);
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy            = (state_q == StLoad) || (state_q == StVerify);
    done            = (state_q == StDone);
    ok              = done && ok_q;
    bus.exp_MW      = (state_q == StLoad) && pack_valid;
    bus.exp_MR      = (state_q == StVerify);
    bus.exp_address = busy ? idx_q[ADDR_SIZE-1:0] : '0;
    bus.exp_data    = bus.exp_MW ? pack_word : '0;
  end

endmodule

// File: tb/tb_mem_stream_loader.sv
module tb_mem_stream_loader;
  import mem_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] count = '0;
  logic       busy, done, ok;
  logic       force_en = 1'b0;

  mem_stream_loader_if #(.ADDR_SIZE(8), .WIDTH(16)) bus ();

  mem_stream_loader #(
    .ADDR_SIZE (8),
    .WIDTH     (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .count (count),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .ok    (ok)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read; optional corruption of addr 1.
  logic [15:0] mem [256];
  always @(posedge clk) if (bus.exp_MW) mem[bus.exp_address] <= bus.exp_data;
  assign bus.exp_out = (force_en && bus.exp_address == 8'd1) ? 16'h0000 : mem[bus.exp_address];

  int n_vec = 0;
  int n_miss = 0;
  int mw_cnt, mr_cnt, rd_idx;
  logic [23:0] exp_q[$];
  logic [15:0] img [256];

  typedef struct {
    int          cnt;
    logic [15:0] w0, w1, w2, w3;
    int          maxgap;
    logic        force_bad;
    logic        exp_ok;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and check the per-cycle scoreboard/protocol rules.
  task automatic tick();
    logic [23:0] e;
    @(posedge clk);
    #1;
    if (busy) chk("mw_mr_exclusive", {31'd0, bus.exp_MW & bus.exp_MR}, 0);
    else      chk("addr_idle_zero", {24'd0, bus.exp_address}, 0);
    if (bus.exp_MW) begin
      mw_cnt++;
      chk("in_ready_on_write", {31'd0, bus.in_ready}, 0);
      chk("write_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", {24'd0, bus.exp_address}, {24'd0, e[23:16]});
        chk("write_data", {16'd0, bus.exp_data}, {16'd0, e[15:0]});
      end
    end else if (busy && !bus.exp_MR) begin
      chk("in_ready_byte_phase", {31'd0, bus.in_ready}, 1);
    end
    if (bus.exp_MR) begin
      mr_cnt++;
      chk("read_addr", {24'd0, bus.exp_address}, rd_idx);
      rd_idx++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int k;
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    bus.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.in_data = 8'($urandom);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      tick();
      k++;
    end
    chk("byte_accept_timeout", {31'd0, bus.in_ready}, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_load(input int cnt, input int maxgap, input logic exp_ok);
    int n;
    int k;
    n = (cnt > 256) ? 256 : cnt;
    mw_cnt = 0;
    mr_cnt = 0;
    rd_idx = 0;
    start = 1'b1;
    count = 9'(cnt);
    tick();
    start = 1'b0;
    for (int w = 0; w < n; w++) begin
      exp_q.push_back({8'(w), img[w]});
      send_byte(img[w][15:8], maxgap);
      send_byte(img[w][7:0], maxgap);
    end
    k = 0;
    while (!done && k < 1000) begin
      tick();
      k++;
    end
    chk("done", {31'd0, done}, 1);
    chk("ok", {31'd0, ok}, {31'd0, exp_ok});
    chk("write_count", mw_cnt, n);
    chk("verify_cycles", mr_cnt, n);
    chk("queue_drained", exp_q.size(), 0);
    for (int w = 0; w < n; w++) chk("mem_contents", {16'd0, mem[w]}, {16'd0, img[w]});
  endtask

  initial begin
    logic [15:0] m0, m1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    vecs[0] = '{2, 16'h1234, 16'hABCD, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
    vecs[1] = '{2, 16'h1234, 16'hABCD, 16'h0000, 16'h0000, 3, 1'b0, 1'b1};
    vecs[2] = '{2, 16'h1234, 16'hABCD, 16'h0000, 16'h0000, 0, 1'b1, 1'b0};
    vecs[3] = '{4, 16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF, 1, 1'b0, 1'b1};
    vecs[4] = '{1, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 2, 1'b0, 1'b1};
    vecs[5] = '{3, 16'hAAAA, 16'h0000, 16'h5555, 16'h0000, 1, 1'b1, 1'b1};

    // Reset held two cycles.
    mw_cnt = 0; mr_cnt = 0; rd_idx = 0;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
    chk("rst_mw", {31'd0, bus.exp_MW}, 0);
    chk("rst_mr", {31'd0, bus.exp_MR}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ok", {31'd0, ok}, 0);
    chk("rst_addr", {24'd0, bus.exp_address}, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      img[0] = vecs[v].w0;
      img[1] = vecs[v].w1;
      img[2] = vecs[v].w2;
      img[3] = vecs[v].w3;
      force_en = vecs[v].force_bad;
      do_load(vecs[v].cnt, vecs[v].maxgap, vecs[v].exp_ok);
      force_en = 1'b0;
      tick();
    end

    // count=0: straight to DONE with ok, no writes.
    m0 = mem[0];
    m1 = mem[1];
    mw_cnt = 0;
    start = 1'b1;
    count = 9'd0;
    tick();
    start = 1'b0;
    chk("cnt0_done", {31'd0, done}, 1);
    chk("cnt0_ok", {31'd0, ok}, 1);
    tick();
    chk("cnt0_no_write", mw_cnt, 0);
    chk("cnt0_mem0", {16'd0, mem[0]}, {16'd0, m0});
    chk("cnt0_mem1", {16'd0, mem[1]}, {16'd0, m1});

    // Load 12 34 AB, start held high meanwhile (must be ignored), then reset.
    img[0] = 16'h1234;
    img[1] = 16'hABCD;
    m1 = mem[1];
    mw_cnt = 0; mr_cnt = 0; rd_idx = 0;
    start = 1'b1;
    count = 9'd2;
    tick();
    count = 9'd0;
    exp_q.push_back({8'd0, 16'h1234});
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    start = 1'b0;
    send_byte(8'hAB, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_mem0_kept", {16'd0, mem[0]}, 32'h1234);
    chk("midrst_mem1_untouched", {16'd0, mem[1]}, {16'd0, m1});
    chk("midrst_one_write", mw_cnt, 1);
    tick();
    img[0] = 16'h5566;
    img[1] = 16'h7788;
    do_load(2, 1, 1'b1);
    tick();

    // Oversized count clamps to the full 256-word memory, ending at address 255.
    for (int i = 0; i < 256; i++) img[i] = 16'(i * 37 + 5) ^ 16'hA5A5;
    do_load(9'h1FF, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
